wave_gen_nco: RTL and testbench

- Parametrised successor to the fixed 8-bit ramp generator that drives the DAC and LEDs.
- Phase-accumulator (NCO) waveform generator with a programmable frequency tuning word (FTW).
- Selectable modes: ramp up, ramp down, triangle, square with duty, DC. Output amplitude is scalable.
- Configured at run time by a byte-command parser fed from the AVR interface receive path (rx_data/new_rx_data).

---
 rtl/wave_gen_nco.sv | 206 ++++++++++++++++++++
 tb/tb_wave_gen_nco.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_gen_nco.sv
// Phase-accumulator waveform generator (ramp/triangle/square/DC) with amplitude
// scaling, configured at run time by a byte-command parser.
module wave_gen_nco #(
   parameter int unsigned          DATA_WIDTH  = 8,
   parameter int unsigned          ACC_WIDTH   = 24,
   parameter logic [ACC_WIDTH-1:0] DEFAULT_FTW = 24'h010000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [7:0]            rx_data,
   input  logic                  new_rx_data,
   output logic [DATA_WIDTH-1:0] wave_out,
   output logic                  sync,
   output logic                  cmd_done,
   output logic                  parser_busy
);

   localparam int unsigned DW      = DATA_WIDTH;
   localparam int unsigned NBYTES  = ACC_WIDTH / 8;
   localparam logic [2:0]  NBYTES_C = 3'(NBYTES);
   localparam logic [DW-1:0] HALF  = {1'b1, {(DW-1){1'b0}}};

   localparam logic [7:0] CMD_FTW  = 8'h46;
   localparam logic [7:0] CMD_MODE = 8'h4D;
   localparam logic [7:0] CMD_AMP  = 8'h41;
   localparam logic [7:0] CMD_DUTY = 8'h44;
   localparam logic [7:0] CMD_RST  = 8'h52;

   typedef enum logic {S_IDLE, S_PAYLOAD} state_t;
   typedef enum logic [1:0] {T_FTW, T_MODE, T_AMP, T_DUTY} target_t;

   state_t  r_state,  w_state_next;
   target_t r_target, w_target_next;
   logic [2:0] r_count, w_count_next;

   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_carry;
   logic [ACC_WIDTH-1:0] r_ftw;
   logic [2:0]           r_mode;
   logic [7:0]           r_amp;
   logic [7:0]           r_duty;
   logic [ACC_WIDTH-1:0] r_shadow;
   logic [DW-1:0]        r_wave;
   logic                 r_sync;
   logic                 r_cmd_done;

   logic [ACC_WIDTH-1:0] w_shadow_next;
   logic                 w_shift;
   logic                 w_load_ftw;
   logic                 w_load_mode;
   logic                 w_load_amp;
   logic                 w_load_duty;
   logic                 w_clear;
   logic                 w_done;
   logic [ACC_WIDTH:0]   w_sum;
   logic [DW-1:0]        w_phase;
   logic [DW-1:0]        w_tri;
   logic [DW-1:0]        w_raw;
   logic [8:0]           w_amp_p1;
   logic [DW+7:0]        w_prod;
   logic [DW-1:0]        w_scaled;

   // ---------------- command parser ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_target <= T_FTW;
         r_count  <= '0;
      end else begin
         r_state  <= w_state_next;
         r_target <= w_target_next;
         r_count  <= w_count_next;
      end
   end

   assign w_shadow_next = (r_shadow << 8) | ACC_WIDTH'(rx_data);

   always_comb begin
      w_state_next  = r_state;
      w_target_next = r_target;
      w_count_next  = r_count;
      w_shift       = 1'b0;
      w_load_ftw    = 1'b0;
      w_load_mode   = 1'b0;
      w_load_amp    = 1'b0;
      w_load_duty   = 1'b0;
      w_clear       = 1'b0;
      w_done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (new_rx_data) begin
               case (rx_data)
                  CMD_FTW: begin
                     w_state_next  = S_PAYLOAD;
                     w_target_next = T_FTW;
                     w_count_next  = NBYTES_C;
                  end
                  CMD_MODE: begin
                     w_state_next  = S_PAYLOAD;
                     w_target_next = T_MODE;
                     w_count_next  = 3'd1;
                  end
                  CMD_AMP: begin
                     w_state_next  = S_PAYLOAD;
                     w_target_next = T_AMP;
                     w_count_next  = 3'd1;
                  end
                  CMD_DUTY: begin
                     w_state_next  = S_PAYLOAD;
                     w_target_next = T_DUTY;
                     w_count_next  = 3'd1;
                  end
                  CMD_RST: begin
                     w_clear = 1'b1;
                     w_done  = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_PAYLOAD: begin
            if (new_rx_data) begin
               w_shift = 1'b1;
               if (r_count == 3'd1) begin
                  // Live register loads from the shadow including this final byte.
                  w_state_next = S_IDLE;
                  w_done       = 1'b1;
                  case (r_target)
                     T_FTW:   w_load_ftw  = 1'b1;
                     T_MODE:  w_load_mode = 1'b1;
                     T_AMP:   w_load_amp  = 1'b1;
                     T_DUTY:  w_load_duty = 1'b1;
                     default: ;
                  endcase
               end else begin
                  w_count_next = r_count - 3'd1;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- waveform datapath ----------------
   assign w_sum    = {1'b0, r_acc} + {1'b0, r_ftw};
   assign w_phase  = r_acc[ACC_WIDTH-1 -: DW];
   assign w_tri    = {w_phase[DW-2:0], 1'b0};
   assign w_amp_p1 = {1'b0, r_amp} + 9'd1;

   always_comb begin
      w_raw = '0;
      case (r_mode)
         3'd0:    w_raw = w_phase;
         3'd1:    w_raw = ~w_phase;
         3'd2:    w_raw = w_phase[DW-1] ? ~w_tri : w_tri;
         3'd3:    w_raw = (w_phase[DW-1 -: 8] < r_duty) ? '1 : '0;
         3'd4:    w_raw = HALF;
         default: w_raw = '0;
      endcase
   end

   // w * 256 never exceeds DW+8 bits, so this product is exact.
   assign w_prod   = {8'd0, w_raw} * {{(DW-1){1'b0}}, w_amp_p1};
   assign w_scaled = DW'(w_prod >> 8);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_carry    <= 1'b0;
         r_ftw      <= DEFAULT_FTW;
         r_mode     <= '0;
         r_amp      <= '1;
         r_duty     <= 8'h80;
         r_shadow   <= '0;
         r_wave     <= '0;
         r_sync     <= 1'b0;
         r_cmd_done <= 1'b0;
      end else begin
         // A clear overrides a simultaneous wrap so no sync follows it.
         if (w_clear) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
         end else if (enable) begin
            r_acc   <= w_sum[ACC_WIDTH-1:0];
            r_carry <= w_sum[ACC_WIDTH];
         end else begin
            r_carry <= 1'b0;
         end
         if (w_shift)     r_shadow <= w_shadow_next;
         if (w_load_ftw)  r_ftw    <= w_shadow_next;
         if (w_load_mode) r_mode   <= w_shadow_next[2:0];
         if (w_load_amp)  r_amp    <= w_shadow_next[7:0];
         if (w_load_duty) r_duty   <= w_shadow_next[7:0];
         r_wave     <= w_scaled;
         r_sync     <= r_carry;
         r_cmd_done <= w_done;
      end
   end

   assign wave_out    = r_wave;
   assign sync        = r_sync;
   assign cmd_done    = r_cmd_done;
   assign parser_busy = (r_state == S_PAYLOAD);

endmodule

// File: tb/tb_wave_gen_nco.sv
// Self-checking bench for wave_gen_nco: directed scenarios plus random command
// traffic compared every cycle against an arithmetic reference model.
module tb_wave_gen_nco;

   localparam int DW = 8;
   localparam int AW = 24;
   localparam logic [AW-1:0] DFTW = 24'h010000;
   localparam longint MOD = longint'(1) << AW;

   localparam int C_F = 8'h46;
   localparam int C_M = 8'h4D;
   localparam int C_A = 8'h41;
   localparam int C_D = 8'h44;
   localparam int C_R = 8'h52;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          new_rx_data = 1'b0;
   logic [DW-1:0] wave_out;
   logic          sync;
   logic          cmd_done;
   logic          parser_busy;

   wave_gen_nco #(
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW),
      .DEFAULT_FTW(DFTW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .rx_data    (rx_data),
      .new_rx_data(new_rx_data),
      .wave_out   (wave_out),
      .sync       (sync),
      .cmd_done   (cmd_done),
      .parser_busy(parser_busy)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   longint m_acc, m_ftw;
   int     m_mode, m_amp, m_duty;
   int     m_wave;
   bit     m_sync, m_done, m_wrapped;
   int     m_cmd, m_need;
   int     m_q[$];

   function automatic int ref_wave(input longint acc);
      int p, w, half, full;
      p    = int'(acc >> (AW - DW));
      half = 1 << (DW - 1);
      full = (1 << DW) - 1;
      case (m_mode)
         0: w = p;
         1: w = full - p;
         2: w = (p < half) ? 2 * p : full - 2 * (p - half);
         3: w = ((p >> (DW - 8)) < m_duty) ? full : 0;
         4: w = half;
         default: w = 0;
      endcase
      return (w * (m_amp + 1)) / 256;
   endfunction

   task automatic m_reset();
      m_acc = 0; m_ftw = DFTW; m_mode = 0; m_amp = 255; m_duty = 128;
      m_wave = 0; m_sync = 0; m_done = 0; m_wrapped = 0;
      m_cmd = 0; m_need = 0; m_q.delete();
   endtask

   task automatic m_step(input bit en, input bit stb, input int b);
      bit     clr;
      int     ld_cmd;
      longint ld_val, sum;
      clr = 0; ld_cmd = 0; ld_val = 0;
      m_wave = ref_wave(m_acc);
      m_sync = m_wrapped;
      m_done = 0;
      if (stb) begin
         if (m_cmd == 0) begin
            if (b == C_F) begin m_cmd = b; m_need = AW / 8; m_q.delete(); end
            else if (b == C_M || b == C_A || b == C_D) begin m_cmd = b; m_need = 1; m_q.delete(); end
            else if (b == C_R) begin clr = 1; m_done = 1; end
         end else begin
            m_q.push_back(b);
            if (m_q.size() == m_need) begin
               foreach (m_q[i]) ld_val = ld_val * 256 + m_q[i];
               ld_cmd = m_cmd;
               m_cmd  = 0;
               m_done = 1;
            end
         end
      end
      if (clr) begin
         m_acc = 0; m_wrapped = 0;
      end else if (en) begin
         sum = m_acc + m_ftw;
         m_wrapped = (sum >= MOD);
         m_acc = sum % MOD;
      end else begin
         m_wrapped = 0;
      end
      if (ld_cmd == C_F) m_ftw = ld_val;
      else if (ld_cmd == C_M) m_mode = int'(ld_val % 8);
      else if (ld_cmd == C_A) m_amp = int'(ld_val);
      else if (ld_cmd == C_D) m_duty = int'(ld_val);
   endtask

   // ---------------- stimulus helpers ----------------
   int cyc = 0;
   int last_sync_cyc = 0;
   int last_gap = 0;

   task automatic tick();
      bit en, stb;
      int b;
      en = enable; stb = new_rx_data; b = int'(rx_data);
      @(posedge clk);
      if (!rst_n) m_reset();
      else m_step(en, stb, b);
      @(negedge clk);
      cyc++;
      check_eq("wave_out", wave_out, m_wave);
      check_eq("sync", sync, m_sync);
      check_eq("cmd_done", cmd_done, m_done);
      check_eq("parser_busy", parser_busy, (m_cmd != 0));
      if (sync === 1'b1) begin
         last_gap = cyc - last_sync_cyc;
         last_sync_cyc = cyc;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input int b);
      rx_data = 8'(b);
      new_rx_data = 1'b1;
      tick();
      new_rx_data = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic send_cmd1(input int c, input int v);
      send_byte(c);
      run($urandom_range(0, 3));
      send_byte(v);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int held;
      m_reset();
      repeat (3) tick();
      check_eq("rst_wave", wave_out, 0);
      check_eq("rst_sync", sync, 0);
      check_eq("rst_done", cmd_done, 0);
      check_eq("rst_busy", parser_busy, 0);

      // Default ramp: one sync per 256 cycles, aligned with wave_out==0
      rst_n = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 530; i++) begin
         tick();
         if (sync === 1'b1) check_eq("sync_at_zero", wave_out, 0);
      end
      check_eq("sync_gap_256", last_gap, 256);

      send_cmd1(C_M, 2);
      run(300);
      send_cmd1(C_M, 0);
      send_cmd1(C_A, 8'h7F);
      run(300);
      send_cmd1(C_A, 8'h00);
      run(300);
      send_cmd1(C_A, 8'hFF);
      send_cmd1(C_M, 3);
      send_cmd1(C_D, 8'h40);
      run(300);
      send_cmd1(C_D, 8'h00);
      run(300);
      send_cmd1(C_D, 8'hFF);
      run(300);
      send_cmd1(C_M, 4);
      run(20);
      send_cmd1(C_M, 6);
      run(20);
      send_cmd1(C_M, 1);
      run(300);
      send_cmd1(C_M, 0);

      // Slow FTW load, bytes 1000 cycles apart
      send_byte(C_F);
      run(1000);
      send_byte(8'h02);
      run(1000);
      send_byte(8'h00);
      run(1000);
      check_eq("busy_before_last", parser_busy, 1);
      send_byte(8'h00);
      run(300);
      check_eq("sync_gap_128", last_gap, 128);

      // Reset in the middle of an FTW command
      send_byte(C_F);
      send_byte(8'h05);
      send_byte(8'h00);
      pulse_reset();
      check_eq("midcmd_busy", parser_busy, 0);
      enable = 1'b1;
      run(600);
      check_eq("midcmd_gap_256", last_gap, 256);

      // 'R' arriving in the same cycle as a wrap
      for (int g = 0; g < 300 && (m_acc + m_ftw < MOD); g++) tick();
      send_byte(C_R);
      check_eq("r_done", cmd_done, 1);
      tick();
      check_eq("r_no_sync", sync, 0);
      check_eq("r_wave_zero", wave_out, 0);
      tick();
      check_eq("r_no_sync2", sync, 0);
      run(50);

      // enable low holds the phase
      held = ref_wave(m_acc);
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("hold_wave", wave_out, held);
         check_eq("hold_sync", sync, 0);
      end
      send_cmd1(C_M, 2);
      run(5);
      enable = 1'b1;

      // Random command traffic
      for (int n = 0; n < 1200; n++) begin
         int k;
         enable = ($urandom_range(0, 7) != 0);
         k = $urandom_range(0, 9);
         case (k)
            0, 1: begin
               send_byte(C_F);
               for (int j = 0; j < AW / 8; j++) begin
                  run($urandom_range(0, 4));
                  send_byte((j == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255));
               end
            end
            2: send_cmd1(C_M, $urandom_range(0, 255));
            3: send_cmd1(C_A, $urandom_range(0, 255));
            4: send_cmd1(C_D, $urandom_range(0, 255));
            5: send_byte(C_R);
            6: send_byte($urandom_range(0, 255));
            7: if ($urandom_range(0, 4) == 0) pulse_reset();
            default: ;
         endcase
         run($urandom_range(0, 30));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
